// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline register with a skid buffer: a main register that drives
// the outputs and a skid register that catches the one beat still in flight
// when downstream stalls. in_ready comes straight from a flop, so the upstream
// handshake never sees a combinational path from out_ready.
module pipe_skid_stage #(
    parameter int CTRL_W     = 9,
    parameter int DATA_W     = 160,
    parameter bit FLUSH_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // EMPTY: nothing held, ONE: main only, FULL: main plus skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d;
    logic [DATA_W-1:0] mainData_q, mainData_d;
    logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;
    logic              inReady_q, inReady_d;
    logic [1:0]        occupancy_q, occupancy_d;

    logic              accept;
    logic              xferOut;

    // A flush squashes the incoming beat, so it never counts as accepted
    assign accept  = in_valid && inReady_q && !flush;
    assign xferOut = (state_q != EMPTY) && out_ready;

    assign in_ready  = inReady_q;
    assign out_valid = (state_q != EMPTY);
    assign out_ctrl  = mainCtrl_q;
    assign out_data  = mainData_q;
    assign occupancy = occupancy_q;

    // Next-state logic: flush wins, otherwise move beats between input, skid and main
    always_comb begin
        state_d    = state_q;
        mainCtrl_d = mainCtrl_q;
        mainData_d = mainData_q;
        skidCtrl_d = skidCtrl_q;
        skidData_d = skidData_q;

        if (flush) begin
            state_d    = EMPTY;
            mainCtrl_d = '0;
            skidCtrl_d = '0;
            skidData_d = '0;
            if (FLUSH_DATA) begin
                mainData_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        mainCtrl_d = in_ctrl;
                        mainData_d = in_data;
                        state_d    = ONE;
                    end
                end
                ONE: begin
                    if (accept && xferOut) begin
                        mainCtrl_d = in_ctrl;
                        mainData_d = in_data;
                    end else if (accept) begin
                        skidCtrl_d = in_ctrl;
                        skidData_d = in_data;
                        state_d    = FULL;
                    end else if (xferOut) begin
                        mainCtrl_d = '0;
                        mainData_d = '0;
                        state_d    = EMPTY;
                    end
                end
                FULL: begin
                    if (xferOut) begin
                        mainCtrl_d = skidCtrl_q;
                        mainData_d = skidData_q;
                        skidCtrl_d = '0;
                        skidData_d = '0;
                        state_d    = ONE;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    mainCtrl_d = '0;
                    mainData_d = '0;
                    skidCtrl_d = '0;
                    skidData_d = '0;
                end
            endcase
        end

        inReady_d = (state_d != FULL);
        case (state_d)
            ONE:     occupancy_d = 2'd1;
            FULL:    occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    // State and payload registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            mainCtrl_q  <= '0;
            mainData_q  <= '0;
            skidCtrl_q  <= '0;
            skidData_q  <= '0;
            inReady_q   <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            mainCtrl_q  <= mainCtrl_d;
            mainData_q  <= mainData_d;
            skidCtrl_q  <= skidCtrl_d;
            skidData_q  <= skidData_d;
            inReady_q   <= inReady_d;
            occupancy_q <= occupancy_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a table of per-cycle handshake vectors, hand-written
// reset/flush sequences and a random run, all checked against a queue model.
// A second instance with FLUSH_DATA=0 shares every input.
module tb_pipe_skid_stage;

    localparam int CW = 9;
    localparam int DW = 160;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic        inValid;
        logic        outReady;
        logic        flush;
        logic [15:0] data;
        logic        expValid;
        logic [1:0]  expOcc;
        logic        expReady;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          inValid;
    logic          outReady;
    logic [CW-1:0] inCtrl;
    logic [DW-1:0] inData;
    logic          inReady,   inReady0;
    logic          outValid,  outValid0;
    logic [CW-1:0] outCtrl,   outCtrl0;
    logic [DW-1:0] outData,   outData0;
    logic [1:0]    occupancy, occupancy0;

    int            checks = 0;
    int            errors = 0;
    beat_t         mq[$];
    logic [DW-1:0] holdData0 = '0;
    vec_t          vecs[$];

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .FLUSH_DATA(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_ctrl(inCtrl), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_ctrl(outCtrl), .out_data(outData),
        .occupancy(occupancy)
    );

    pipe_skid_stage #(.CTRL_W(CW), .DATA_W(DW), .FLUSH_DATA(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(inValid), .in_ready(inReady0), .in_ctrl(inCtrl), .in_data(inData),
        .out_valid(outValid0), .out_ready(outReady), .out_ctrl(outCtrl0), .out_data(outData0),
        .occupancy(occupancy0)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare both instances against the model after an edge
    task automatic checkState();
        logic [CW-1:0] eCtrl;
        logic [DW-1:0] eData;
        logic [DW-1:0] eData0;
        eCtrl  = (mq.size() > 0) ? mq[0].ctrl : '0;
        eData  = (mq.size() > 0) ? mq[0].data : '0;
        eData0 = (mq.size() > 0) ? mq[0].data : holdData0;
        checkOutput("out_valid", DW'(outValid), DW'(mq.size() > 0));
        checkOutput("occupancy", DW'(occupancy), DW'(mq.size()));
        checkOutput("in_ready",  DW'(inReady), DW'(mq.size() < 2));
        checkOutput("out_ctrl",  DW'(outCtrl), DW'(eCtrl));
        checkOutput("out_data",  outData, eData);
        checkOutput("occ_le_2",  DW'(occupancy <= 2'd2), DW'(1));
        checkOutput("fd0_out_valid", DW'(outValid0), DW'(mq.size() > 0));
        checkOutput("fd0_occupancy", DW'(occupancy0), DW'(mq.size()));
        checkOutput("fd0_out_ctrl",  DW'(outCtrl0), DW'(eCtrl));
        checkOutput("fd0_out_data",  outData0, eData0);
    endtask

    // One clock of the current inputs; scoreboard pops/compares consumed beats
    task automatic applyStimulus();
        beat_t         b;
        logic          acc;
        logic          xfer;
        logic [DW-1:0] preData0;
        acc      = inValid && (mq.size() < 2) && !flush;
        xfer     = (mq.size() > 0) && outReady;
        preData0 = (mq.size() > 0) ? mq[0].data : holdData0;
        if (xfer) begin
            b = mq.pop_front();
            checkOutput("consume_ctrl", DW'(outCtrl), DW'(b.ctrl));
            checkOutput("consume_data", outData, b.data);
        end
        if (flush) begin
            holdData0 = preData0;
            mq.delete();
        end else begin
            if (acc) mq.push_back({inCtrl, inData});
            if (xfer && mq.size() == 0) holdData0 = '0;
        end
        @(posedge clk);
        #1;
        checkState();
    endtask

    function automatic vec_t mk(input logic v, input logic r, input logic f,
                                input logic [15:0] d, input logic ev,
                                input logic [1:0] eo, input logic er);
        vec_t x;
        x.inValid  = v;
        x.outReady = r;
        x.flush    = f;
        x.data     = d;
        x.expValid = ev;
        x.expOcc   = eo;
        x.expReady = er;
        return x;
    endfunction

    task automatic drive(input logic v, input logic r, input logic f,
                         input logic [CW-1:0] c, input logic [DW-1:0] d);
        inValid  = v;
        outReady = r;
        flush    = f;
        inCtrl   = c;
        inData   = d;
    endtask

    initial begin
        // Streaming 1..8 at full throughput
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 1, 0, 16'(i), 1, 2'd1, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0,  0, 2'd0, 1));
        // Stall: A then B fill the stage, a third offer is refused, then drain in order
        vecs.push_back(mk(1, 0, 0, 16'hA,  1, 2'd1, 1));
        vecs.push_back(mk(1, 0, 0, 16'hB,  1, 2'd2, 0));
        vecs.push_back(mk(1, 0, 0, 16'hEE, 1, 2'd2, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0,  1, 2'd1, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0,  0, 2'd0, 1));
        // Flush in FULL with a beat (0xC) offered in the same cycle
        vecs.push_back(mk(1, 0, 0, 16'h11, 1, 2'd1, 1));
        vecs.push_back(mk(1, 0, 0, 16'h12, 1, 2'd2, 0));
        vecs.push_back(mk(1, 0, 1, 16'hC,  0, 2'd0, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0,  0, 2'd0, 1));
        // Flush in ONE coinciding with a transfer-out, then flush in EMPTY
        vecs.push_back(mk(1, 1, 0, 16'h21, 1, 2'd1, 1));
        vecs.push_back(mk(1, 1, 1, 16'h22, 0, 2'd0, 1));
        vecs.push_back(mk(1, 1, 1, 16'h23, 0, 2'd0, 1));
        vecs.push_back(mk(1, 1, 0, 16'h24, 1, 2'd1, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0,  0, 2'd0, 1));

        rst = 1'b1;
        drive(0, 0, 0, '0, '0);
        #1;
        checkOutput("reset_out_valid", DW'(outValid), DW'(0));
        checkOutput("reset_occupancy", DW'(occupancy), DW'(0));
        checkOutput("reset_in_ready",  DW'(inReady), DW'(1));
        checkOutput("reset_out_ctrl",  DW'(outCtrl), DW'(0));
        checkOutput("reset_out_data",  outData, DW'(0));
        #11 rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].inValid, vecs[i].outReady, vecs[i].flush,
                  {1'b1, vecs[i].data[7:0]}, DW'(vecs[i].data));
            applyStimulus();
            checkOutput($sformatf("vec%0d_valid", i), DW'(outValid), DW'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d_occ", i),   DW'(occupancy), DW'(vecs[i].expOcc));
            checkOutput($sformatf("vec%0d_ready", i), DW'(inReady), DW'(vecs[i].expReady));
        end

        // Async reset in ONE drops the outputs before the next edge
        drive(1, 0, 0, 9'h066, DW'(16'h66));
        applyStimulus();
        checkOutput("pre_reset_valid", DW'(outValid), DW'(1));
        drive(0, 0, 0, '0, '0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_out_valid", DW'(outValid), DW'(0));
        checkOutput("async_out_ctrl",  DW'(outCtrl), DW'(0));
        checkOutput("async_occupancy", DW'(occupancy), DW'(0));
        checkOutput("async_in_ready",  DW'(inReady), DW'(1));
        mq.delete();
        holdData0 = '0;
        #2 rst = 1'b0;
        drive(1, 1, 0, 9'h077, DW'(16'h77));
        applyStimulus();
        checkOutput("post_reset_data", outData, DW'(16'h77));

        // FLUSH_DATA=0 keeps the data bundle on flush
        drive(0, 1, 0, '0, '0);
        applyStimulus();
        drive(1, 0, 0, 9'h0AA, DW'(16'h55));
        applyStimulus();
        drive(0, 0, 1, '0, '0);
        applyStimulus();
        checkOutput("fd0_flush_valid", DW'(outValid0), DW'(0));
        checkOutput("fd0_flush_ctrl",  DW'(outCtrl0), DW'(0));
        checkOutput("fd0_flush_data",  outData0, DW'(16'h55));
        checkOutput("fd1_flush_data",  outData, DW'(0));

        // Random handshakes with occasional flushes
        for (int n = 0; n < 10000; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0),
                  CW'($urandom),
                  {$urandom, $urandom, $urandom, $urandom, $urandom});
            applyStimulus();
        end

        drive(0, 1, 0, '0, '0);
        applyStimulus();
        applyStimulus();
        checkOutput("final_empty", DW'(mq.size()), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter CTRL_W, default 9: width of the control bundle (RegDst..RegWrite class signals).
REQ-002 Parameter DATA_W, default 160: width of the data bundle (for example five 32-bit words).
REQ-003 Parameter FLUSH_DATA, default 1: 1 = data bundle zeroed on flush; 0 = data bundle held on flush, with control still zeroed.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 in_valid  input  1  upstream offers a beat.
REQ-008 in_ready  output  1  stage accepts the beat this cycle; driven only by a register.
REQ-009 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-010 in_data  input  DATA_W  upstream data bundle.
REQ-011 out_valid  output  1  output register holds a live beat.
REQ-012 out_ready  input  1  downstream consumes the beat; low = stall.
REQ-013 out_ctrl  output  CTRL_W  registered control; all-zero whenever out_valid=0 (bubble = NOP).
REQ-014 out_data  output  DATA_W  registered data.
REQ-015 occupancy  output  2  number of held beats, 0..2.

Function
REQ-016 Storage: one main register (drives out_*) plus one skid register. Combined state: EMPTY (0 beats), ONE (main only), FULL (main+skid).
REQ-017 Accept: a beat is accepted when in_valid=1, in_ready=1 and flush=0. Transfer-out occurs when out_valid=1 and out_ready=1.
REQ-018 in_ready = NOT skid_valid, registered; it is 1 in EMPTY and ONE and 0 in FULL.
REQ-019 Latency: a beat accepted in EMPTY appears on out_* the next cycle (1-cycle latency).
REQ-020 EMPTY + accept -> ONE, with the beat loaded into main.
REQ-021 ONE + accept + transfer-out -> ONE, with the new beat in main (full throughput, one beat per cycle).
REQ-022 ONE + accept without transfer-out -> FULL, with the new beat in skid and in_ready going 0 next cycle.
REQ-023 ONE + transfer-out without accept -> EMPTY, with out_ctrl and out_data zeroed.
REQ-024 FULL + transfer-out -> ONE, with skid moved to main and in_ready going 1 next cycle. No accept is possible in FULL.
REQ-025 Any other combination holds state; out_* are stable while out_valid=1 and out_ready=0.
REQ-026 Beats leave in acceptance order; no beat is dropped or duplicated except on flush.
REQ-027 flush=1 takes priority over every other event. Next state is EMPTY, the same-cycle input beat is discarded, and any same-cycle transfer-out still counts as consumed by downstream.
REQ-028 After flush: out_ctrl=0. out_data=0 when FLUSH_DATA=1; otherwise out_data keeps its value. The skid register is invalidated.
REQ-029 occupancy equals the number of valid entries after every edge (EMPTY=0, ONE=1, FULL=2); the value 3 never occurs.
REQ-030 in_ctrl and in_data are captured without modification; the block performs no arithmetic.

Reset
REQ-031 While rst=1, asynchronously: out_valid=0, out_ctrl=0, out_data=0, skid register and its valid flag=0, occupancy=0, in_ready=1.
REQ-032 Reset asserted mid-operation (ONE or FULL) discards all held beats immediately, without waiting for a clock edge.
REQ-033 The first accept is possible on the first rising edge after rst deasserts.

Verification
REQ-034 Streaming: out_ready=1, in_valid=1 for 8 cycles, in_data=1..8 -> out_data=1..8 on consecutive cycles, each one cycle after its accept; in_ready stays 1 throughout.
REQ-035 Stall: accept A=0xA, then hold out_ready=0 while offering B=0xB -> occupancy=2 and in_ready=0. Raise out_ready -> A and then B are output in order, and in_ready returns to 1 one cycle after A leaves.
REQ-036 Flush in FULL with in_valid=1 and in_data=0xC -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and 0xC never appears on the output.
REQ-037 Async reset: assert rst mid-cycle in state ONE -> out_valid and out_ctrl drop to 0 before the next edge. After release, a beat offered on the first edge appears on out_* one cycle later.
REQ-038 FLUSH_DATA=0: flush while out_data=0x55 -> out_valid=0, out_ctrl=0, out_data remains 0x55.
REQ-039 Random in_valid/out_ready for 10k cycles against a reference queue model -> order and count match, occupancy never exceeds 2, and out_* never change while stalled.
